instr_fetch: RTL

//  Instruction fetch stage: owns the PC and issues requests to instruction memory

---
 rtl/instr_fetch_if.sv | 24 ++
 rtl/instr_fetch.sv | 113 +++++++++++
 2 files changed

// File: rtl/instr_fetch_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : instr_fetch_if
// Description : Instruction-memory request/response bundle.
//               master = fetch stage, slave = instruction memory.
//   req    master->slave  request valid
//   addr   master->slave  word-aligned request address
//   ready  slave->master  request accepted this cycle
//   rvalid slave->master  read data valid, one per accepted request
//   rdata  slave->master  instruction word
// Revision    : 1.0  initial release
// ============================================================================
interface instr_fetch_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, output addr, input ready, input rvalid, input rdata);
  modport slave  (input req, input addr, output ready, output rvalid, output rdata);
endinterface
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : instr_fetch
// Description : Instruction fetch stage. Owns the PC, issues one request at a
//               time to instruction memory (req/ready + rvalid, any latency)
//               and presents {pc_out, instr_out, instr_valid} to IF/ID.
//               Handles downstream stall and branch/jump redirect (flush).
// Ports       : clk               posedge clock
//               reset             asynchronous active-high reset
//               i_stall           downstream cannot accept, hold output
//               i_redirect_valid  redirect taken this cycle
//               i_redirect_pc     redirect target (low 2 bits ignored)
//               imem              instruction memory bus (master side)
//               o_pc_out          PC of o_instr_out
//               o_instr_out       fetched instruction, 0 when flushed
//               o_instr_valid     output holds a live instruction
// Revision    : 1.0  initial release
// ============================================================================
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic        i_stall,
  input  wire logic        i_redirect_valid,
  input  wire logic [31:0] i_redirect_pc,
  instr_fetch_if.master    imem,
  output      logic [31:0] o_pc_out,
  output      logic [31:0] o_instr_out,
  output      logic        o_instr_valid
);

  localparam logic [31:0] c_pc_inc = 32'(PC_STEP);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,  // issue request
    S_WAIT = 2'd1,  // request accepted, awaiting data
    S_HOLD = 2'd2,  // data delivered while stalled
    S_DROP = 2'd3   // in-flight response is stale, discard it
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_capture;
  logic [31:0] r_pc;
  logic [31:0] r_pc_out;
  logic [31:0] r_instr_out;
  logic        r_instr_valid;

  // Request is suppressed combinationally while reset is held.
  assign imem.req      = (r_state == S_REQ) && !reset;
  assign imem.addr     = r_pc;
  assign o_pc_out      = r_pc_out;
  assign o_instr_out   = r_instr_out;
  assign o_instr_valid = r_instr_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_REQ;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    if (i_redirect_valid) begin
      // Redirect wins; only an already-accepted request forces a drop.
      case (r_state)
        S_REQ:   w_state_nxt = imem.ready  ? S_DROP : S_REQ;
        S_WAIT:  w_state_nxt = imem.rvalid ? S_REQ  : S_DROP;
        S_HOLD:  w_state_nxt = S_REQ;
        S_DROP:  w_state_nxt = imem.rvalid ? S_REQ  : S_DROP;
        default: w_state_nxt = S_REQ;
      endcase
    end else begin
      case (r_state)
        S_REQ:  if (imem.ready) w_state_nxt = S_WAIT;
        S_WAIT: if (imem.rvalid) begin
                  w_capture   = 1'b1;
                  w_state_nxt = i_stall ? S_HOLD : S_REQ;
                end
        S_HOLD: if (!i_stall) w_state_nxt = S_REQ;
        S_DROP: if (imem.rvalid) w_state_nxt = S_REQ;
        default: w_state_nxt = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_pc_out      <= 32'h0;
      r_instr_out   <= 32'h0;
      r_instr_valid <= 1'b0;
    end else if (i_redirect_valid) begin
      // pc_out deliberately kept; only the instruction is flushed.
      r_pc          <= i_redirect_pc & ~32'h3;
      r_instr_out   <= 32'h0;
      r_instr_valid <= 1'b0;
    end else if (w_capture) begin
      r_pc_out      <= r_pc;
      r_instr_out   <= imem.rdata;
      r_instr_valid <= 1'b1;
      r_pc          <= r_pc + c_pc_inc;
    end else if (r_instr_valid && !i_stall) begin
      // Consumed by IF/ID and not refilled on this edge.
      r_instr_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire
